// File: rtl/ysyx_22041461_regfile_sb.sv
// GPR file with a per-register pending-write scoreboard for the pipelined NPC core.
// Decode/issue reads operands and marks destinations pending. Writeback selects the
// result source, writes the register and retires one pending write.
// x0 is hard-wired to zero. A sticky err flag records issue overflow and retire underflow.
// Optional feature: define YSYX_22041461_REGFILE_WB_BYPASS_EN to forward the writeback
// value and the decremented busy state to matching read ports in the same cycle.
module ysyx_22041461_regfile_sb #(
  parameter int XLEN    = 64,
  parameter int NREG    = 32,
  parameter int AW      = $clog2(NREG),
  parameter int NRD     = 2,
  parameter int MAXPEND = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]    rd_busy,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_rd,
  output logic              iss_ready,
  input  logic              wb_valid,
  input  logic [AW-1:0]     wb_rd,
  input  logic [2:0]        wb_sel,
  input  logic [XLEN-1:0]   wb_alu,
  input  logic [XLEN-1:0]   wb_pc,
  input  logic [XLEN-1:0]   wb_snpc,
  input  logic [XLEN-1:0]   wb_imm,
  input  logic [XLEN-1:0]   wb_mem,
  output logic              pend_any,
  output logic              err
);

  localparam int PW = $clog2(MAXPEND + 1);

  logic [XLEN-1:0] regs [NREG];
  logic [PW-1:0]   pend [NREG];
  logic [AW-1:0]   raddr [NRD];

  logic            sel_ok;
  logic [XLEN-1:0] wb_data;
  logic            iss_fire;
  logic            wb_fire;
  logic            ovf;
  logic            udf;
  logic [NREG-1:0] inc_v;
  logic [NREG-1:0] dec_v;

  // Pick the writeback source; unlisted select codes write nothing.
  always_comb begin
    sel_ok  = 1'b0;
    wb_data = '0;
    case (wb_sel)
      3'b001: begin sel_ok = 1'b1; wb_data = wb_alu;  end
      3'b010: begin sel_ok = 1'b1; wb_data = wb_pc;   end
      3'b011: begin sel_ok = 1'b1; wb_data = wb_snpc; end
      3'b100: begin sel_ok = 1'b1; wb_data = wb_imm;  end
      3'b101: begin sel_ok = 1'b1; wb_data = wb_mem;  end
      default: begin sel_ok = 1'b0; wb_data = '0; end
    endcase
  end

  // Ready depends only on the registered count so it never loops through wb_*.
  assign iss_ready = (pend[iss_rd] != PW'(MAXPEND));
  assign iss_fire  = iss_valid & iss_ready & (iss_rd != '0);
  assign wb_fire   = wb_valid & (wb_rd != '0);
  assign ovf       = iss_valid & ~iss_ready;
  assign udf       = wb_fire & (pend[wb_rd] == '0) & ~(iss_fire & (iss_rd == wb_rd));

  // One-hot increment/decrement requests per register.
  always_comb begin
    inc_v = '0;
    dec_v = '0;
    if (iss_fire) inc_v[iss_rd] = 1'b1;
    if (wb_fire)  dec_v[wb_rd]  = 1'b1;
  end

  // OR-reduce the scoreboard so the core can tell when the pipeline is drained.
  always_comb begin
    pend_any = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      if (pend[i] != '0) pend_any = 1'b1;
    end
  end

  // Register storage; x0 is never written so it stays zero after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wb_fire && sel_ok) begin
      regs[wb_rd] <= wb_data;
    end
  end

  // Pending counters: a same-register issue and retire cancel out, and the count saturates at both ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) pend[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (inc_v[i] && !dec_v[i]) begin
          pend[i] <= pend[i] + PW'(1);
        end else if (dec_v[i] && !inc_v[i] && (pend[i] != '0)) begin
          pend[i] <= pend[i] - PW'(1);
        end
      end
    end
  end

  // Sticky protocol error, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (ovf || udf) begin
      err <= 1'b1;
    end
  end

  // Unpack the read addresses.
  always_comb begin
    for (int k = 0; k < NRD; k++) raddr[k] = rd_addr[k*AW +: AW];
  end

  // Read ports, with optional same-cycle forwarding of the writeback.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int k = 0; k < NRD; k++) begin
      if (raddr[k] != '0) begin
        rd_data[k*XLEN +: XLEN] = regs[raddr[k]];
        rd_busy[k]              = (pend[raddr[k]] != '0);
`ifdef YSYX_22041461_REGFILE_WB_BYPASS_EN
        if (wb_fire && (raddr[k] == wb_rd)) begin
          if (sel_ok) rd_data[k*XLEN +: XLEN] = wb_data;
          rd_busy[k] = (pend[raddr[k]] > PW'(1));
        end
`else
`endif
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22041461_regfile_sb.sv
// Directed self-checking bench for ysyx_22041461_regfile_sb (default parameters).
// Expectations follow YSYX_22041461_REGFILE_WB_BYPASS_EN if it is defined.
module tb_ysyx_22041461_regfile_sb;

  localparam int XLEN = 64;
  localparam int AW   = 5;
  localparam int NRD  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]    rd_busy;
  logic              iss_valid;
  logic [AW-1:0]     iss_rd;
  logic              iss_ready;
  logic              wb_valid;
  logic [AW-1:0]     wb_rd;
  logic [2:0]        wb_sel;
  logic [XLEN-1:0]   wb_alu, wb_pc, wb_snpc, wb_imm, wb_mem;
  logic              pend_any;
  logic              err;

  int compared   = 0;
  int mismatched = 0;

  ysyx_22041461_regfile_sb dut (
    .clk(clk), .rst(rst),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_sel(wb_sel),
    .wb_alu(wb_alu), .wb_pc(wb_pc), .wb_snpc(wb_snpc), .wb_imm(wb_imm), .wb_mem(wb_mem),
    .pend_any(pend_any), .err(err)
  );

  always #5 clk = ~clk;

  // Advance to just past the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drop issue and writeback requests.
  task automatic applyStimulus();
    iss_valid = 1'b0;
    wb_valid  = 1'b0;
    wb_sel    = 3'b000;
  endtask

  task automatic setAddr(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_addr = {a1, a0};
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [XLEN-1:0] observed,
                             input logic [XLEN-1:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [XLEN-1:0] port0();
    return rd_data[XLEN-1:0];
  endfunction

  function automatic logic [XLEN-1:0] port1();
    return rd_data[2*XLEN-1:XLEN];
  endfunction

  initial begin
    rst = 1'b1;
    rd_addr = '0;
    iss_rd = '0; wb_rd = '0;
    wb_alu = '0; wb_pc = '0; wb_snpc = '0; wb_imm = '0; wb_mem = '0;
    applyStimulus();
    #3;
    checkOutput("rst_data0", port0(), 64'h0);
    checkOutput("rst_busy", 64'(rd_busy), 64'h0);
    checkOutput("rst_ready", 64'(iss_ready), 64'h1);
    checkOutput("rst_pend_any", 64'(pend_any), 64'h0);
    checkOutput("rst_err", 64'(err), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Same-cycle issue and retire on x4 leave the count at 1.
    iss_valid = 1'b1; iss_rd = 5'd4;
    tick();
    iss_valid = 1'b1; iss_rd = 5'd4;
    wb_valid = 1'b1; wb_rd = 5'd4; wb_sel = 3'b001; wb_alu = 64'h44;
    tick();
    applyStimulus();
    setAddr(5'd4, 5'd0);
    checkOutput("same_data", port0(), 64'h44);
    checkOutput("same_busy", 64'(rd_busy[0]), 64'h1);
    checkOutput("same_pend_any", 64'(pend_any), 64'h1);
    checkOutput("same_err", 64'(err), 64'h0);
    wb_valid = 1'b1; wb_rd = 5'd4; wb_sel = 3'b000; wb_alu = 64'h99;
    tick();
    applyStimulus();
    #1;
    checkOutput("retire_nowrite_data", port0(), 64'h44);
    checkOutput("retire_busy", 64'(rd_busy[0]), 64'h0);
    checkOutput("retire_pend_any", 64'(pend_any), 64'h0);

    // Fill x3 to the limit, then overflow.
    iss_valid = 1'b1; iss_rd = 5'd3;
    tick(); tick(); tick();
    iss_valid = 1'b0;
    setAddr(5'd3, 5'd0);
    checkOutput("full_ready", 64'(iss_ready), 64'h0);
    checkOutput("full_busy", 64'(rd_busy[0]), 64'h1);
    checkOutput("full_err", 64'(err), 64'h0);
    iss_valid = 1'b1;
    tick();
    applyStimulus();
    #1;
    checkOutput("ovf_err", 64'(err), 64'h1);
    wb_valid = 1'b1; wb_rd = 5'd3; wb_sel = 3'b000;
    tick(); tick();
    applyStimulus();
    #1;
    checkOutput("drain2_busy", 64'(rd_busy[0]), 64'h1);
    checkOutput("drain2_ready", 64'(iss_ready), 64'h1);
    wb_valid = 1'b1; wb_rd = 5'd3; wb_sel = 3'b000;
    tick();
    applyStimulus();
    #1;
    checkOutput("drain3_busy", 64'(rd_busy[0]), 64'h0);
    checkOutput("drain3_pend_any", 64'(pend_any), 64'h0);

    // A reset pulse clears the sticky error.
    rst = 1'b1;
    #2;
    checkOutput("rst2_err", 64'(err), 64'h0);
    rst = 1'b0;
    tick();

    // Memory writeback into x7, then an attempted write to x0.
    wb_valid = 1'b1; wb_rd = 5'd7; wb_sel = 3'b101; wb_mem = 64'hDEADBEEF;
    tick();
    applyStimulus();
    setAddr(5'd7, 5'd0);
    checkOutput("x7_mem", port0(), 64'hDEADBEEF);
    checkOutput("udf7_err", 64'(err), 64'h1);
    checkOutput("udf7_pend_any", 64'(pend_any), 64'h0);
    wb_valid = 1'b1; wb_rd = 5'd0; wb_sel = 3'b101; wb_mem = 64'hFFFF;
    tick();
    applyStimulus();
    setAddr(5'd0, 5'd7);
    checkOutput("x0_zero", port0(), 64'h0);
    checkOutput("x7_keep", port1(), 64'hDEADBEEF);

    // Underflow write to x9, and the remaining source selects.
    wb_valid = 1'b1; wb_rd = 5'd9; wb_sel = 3'b001; wb_alu = 64'h55;
    tick();
    wb_rd = 5'd10; wb_sel = 3'b010; wb_pc = 64'h8000_0000;
    tick();
    wb_rd = 5'd11; wb_sel = 3'b011; wb_snpc = 64'h8000_0004;
    tick();
    wb_rd = 5'd13; wb_sel = 3'b110; wb_imm = 64'h77;
    tick();
    applyStimulus();
    setAddr(5'd9, 5'd10);
    checkOutput("x9_alu", port0(), 64'h55);
    checkOutput("x9_busy", 64'(rd_busy[0]), 64'h0);
    checkOutput("x10_pc", port1(), 64'h8000_0000);
    setAddr(5'd11, 5'd13);
    checkOutput("x11_snpc", port0(), 64'h8000_0004);
    checkOutput("x13_badsel", port1(), 64'h0);
    checkOutput("udf_err_sticky", 64'(err), 64'h1);

    // Immediate writeback into pending x6: same-cycle view, then next cycle.
    iss_valid = 1'b1; iss_rd = 5'd6;
    tick();
    applyStimulus();
    wb_valid = 1'b1; wb_rd = 5'd6; wb_sel = 3'b100; wb_imm = 64'hABC;
    setAddr(5'd6, 5'd0);
`ifdef YSYX_22041461_REGFILE_WB_BYPASS_EN
    checkOutput("x6_same_data", port0(), 64'hABC);
    checkOutput("x6_same_busy", 64'(rd_busy[0]), 64'h0);
`else
    checkOutput("x6_same_data", port0(), 64'h0);
    checkOutput("x6_same_busy", 64'(rd_busy[0]), 64'h1);
`endif
    tick();
    applyStimulus();
    #1;
    checkOutput("x6_next_data", port0(), 64'hABC);
    checkOutput("x6_next_busy", 64'(rd_busy[0]), 64'h0);

    // Write x5 while issuing x8, then reset asynchronously mid-cycle.
    wb_valid = 1'b1; wb_rd = 5'd5; wb_sel = 3'b001; wb_alu = 64'h1234;
    iss_valid = 1'b1; iss_rd = 5'd8;
    tick();
    applyStimulus();
    setAddr(5'd5, 5'd8);
    checkOutput("x5_write", port0(), 64'h1234);
    checkOutput("x8_busy", 64'(rd_busy[1]), 64'h1);
    checkOutput("pre_rst_pend_any", 64'(pend_any), 64'h1);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("async_x5", port0(), 64'h0);
    checkOutput("async_pend_any", 64'(pend_any), 64'h0);
    checkOutput("async_err", 64'(err), 64'h0);
    checkOutput("async_busy", 64'(rd_busy), 64'h0);
    rst = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ysyx_22041461_regfile_sb.md
Name: ysyx_22041461_regfile_sb

Overview:
- Parametrised GPR file with per-register pending-write scoreboard for the pipelined NPC core.
- Sits between decode/issue (reads, marks destinations pending) and writeback (selects result source, writes, retires pending).
- Generalises the single-cycle register file: width, depth and read-port count are parameters; multiple in-flight writes per register are tracked; protocol errors are flagged.

Parameters:
- XLEN, 64, data width.
- NREG, 32, number of registers; x0 is hard-wired to zero.
- AW, $clog2(NREG), register address width.
- NRD, 2, number of read ports.
- MAXPEND, 3, maximum outstanding writes per register; counter width PW = $clog2(MAXPEND+1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- rd_addr  in  NRD*AW  read addresses; port k is bits [k*AW +: AW].
- rd_data  out  NRD*XLEN  read data, combinational.
- rd_busy  out  NRD  port k's register has pending writes.
- iss_valid  in  1  issue marks iss_rd pending.
- iss_rd  in  AW  destination being issued.
- iss_ready  out  1  pending[iss_rd] != MAXPEND.
- wb_valid  in  1  writeback event.
- wb_rd  in  AW  writeback destination.
- wb_sel  in  3  source select: 000 none, 001 alu, 010 pc, 011 snpc, 100 imm, 101 mem, others none.
- wb_alu, wb_pc, wb_snpc, wb_imm, wb_mem  in  XLEN each  writeback candidates.
- pend_any  out  1  OR of all pending counters != 0.
- err  out  1  sticky protocol-error flag.

Behaviour:
- Reset (async, rst=1): all registers 0, all pending counters 0, err 0. rd_data reads 0, rd_busy 0, iss_ready 1, pend_any 0. Reset mid-operation discards all in-flight state.
- Read: rd_data[k] = x[rd_addr[k]]; address 0 always yields 0. rd_busy[k] = pending[rd_addr[k]] != 0. Both reflect registered state.
- Write: at posedge, if wb_valid, wb_sel is in 001..101 and wb_rd != 0, x[wb_rd] <= the selected source. Writes take effect next cycle (1-cycle latency). Writes to x0 are discarded.
- Issue: iss_fire = iss_valid & iss_ready & (iss_rd != 0). iss_fire increments pending[iss_rd].
- iss_ready has no combinational dependence on wb_*. iss_rd = 0 gives iss_ready = 1 and no counter change.
- Retire: wb_fire = wb_valid & (wb_rd != 0). wb_fire decrements pending[wb_rd] regardless of wb_sel; sel 000 retires without writing.
- Same cycle, same register, iss_fire and wb_fire: counter unchanged. Different registers: both updated independently.
- Underflow: wb_fire with pending[wb_rd] = 0 and no same-cycle iss_fire to wb_rd. The counter stays 0, data is still written, and err sets.
- Overflow: iss_valid & !iss_ready is ignored (no increment), and err sets.
- err clears only on reset.
- Counters never wrap in either direction.

Optional Feature:
- Macro YSYX_22041461_REGFILE_WB_BYPASS_EN.
- Defined: if wb_valid, wb_rd != 0, wb_sel is valid and rd_addr[k] == wb_rd, then rd_data[k] = the selected wb source in the same cycle. In that case rd_busy[k] = (pending[wb_rd] - 1 != 0), saturating at 0.
- Defined, wb_sel = 000: the data path is not bypassed, but rd_busy still uses the decremented count.
- Undefined: reads and rd_busy reflect registered state only; writeback is visible one cycle later.

Test Plan:
- Assert rst mid-run after writing x5=0x1234 → x5 reads 0, pend_any=0, err=0 asynchronously, before the next clk edge.
- wb_valid, wb_rd=7, wb_sel=101, wb_mem=0xDEADBEEF → next cycle rd_addr=7 returns 0xDEADBEEF. Repeat with wb_rd=0 → x0 still reads 0.
- Issue rd=3 three times → iss_ready=0 for rd=3. A 4th issue → ignored, err=1. Three wb to rd=3 → rd_busy=0, pend_any=0.
- Same cycle: iss rd=4 and wb rd=4 with pending[4]=1 → pending stays 1, rd_busy=1, err=0.
- wb rd=9 with pending[9]=0, wb_sel=001, wb_alu=0x55 → x9=0x55, err=1, pending[9]=0.
- Bypass build: pending[6]=1, wb rd=6, sel=100, wb_imm=0xABC, rd_addr=6 → rd_data=0xABC and rd_busy=0 the same cycle. Non-bypass build: old value and rd_busy=1, then 0xABC the next cycle.
